// File: rtl/snake_engine.sv
// snake_engine: game-logic core for the 16x16 snake game.
//
// Owns the snake body (16 slots of {row, col}), the travel direction, the food cell, the
// food-placement LFSR and the game state. Everything the renderer consumes is a register.
//
// Parameters
//   MAX_LEN    length that wins the game (4..15)
//   LFSR_SEED  non-zero LFSR value loaded on init
//
// Ports
//   Clk             system clock
//   Reset           synchronous, active-high reset
//   Start           one-cycle pulse: Qi -> Qc, and Qw/Ql -> init (Qi)
//   BtnU/D/L/R      debounced direction requests, level-sampled every cycle
//   Tick            one-cycle move strobe
//   Food            food cell {row[3:0], col[3:0]}
//   Length          number of active segments
//   Locations_Flat  16 x 8-bit segments, head in [127:120], segment k in [127-8k -: 8]
//   Qi/Qc/Qw/Ql     one-hot game state: init, running, win, lose

`timescale 1ns/1ps

module snake_engine #(
  parameter int unsigned MAX_LEN   = 15,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         BtnU,
  input  logic         BtnD,
  input  logic         BtnL,
  input  logic         BtnR,
  input  logic         Tick,
  output logic [7:0]   Food,
  output logic [3:0]   Length,
  output logic [127:0] Locations_Flat,
  output logic         Qi,
  output logic         Qc,
  output logic         Qw,
  output logic         Ql
);

  // One-hot state encoding so the Q outputs come straight off flops.
  localparam logic [3:0] StInit = 4'b0001;
  localparam logic [3:0] StRun  = 4'b0010;
  localparam logic [3:0] StWin  = 4'b0100;
  localparam logic [3:0] StLose = 4'b1000;

  // Encoded so that the reverse of a direction is dir ^ 2'b01.
  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirDown  = 2'd1;
  localparam logic [1:0] DirLeft  = 2'd2;
  localparam logic [1:0] DirRight = 2'd3;

  localparam logic [7:0] InitHead = 8'h88;
  localparam logic [7:0] InitSeg1 = 8'h87;
  localparam logic [7:0] InitSeg2 = 8'h86;
  localparam logic [7:0] InitFood = 8'h8C;
  localparam logic [3:0] InitLen  = 4'd3;

  logic [3:0] state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [3:0] len_q, len_d;
  logic [7:0] food_q, food_d;
  logic       pend_q, pend_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] seg_q [16];
  logic [7:0] seg_d [16];

  // ---------------------------------------------------------------------------------------------
  // LFSR: x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting towards the MSB.
  // ---------------------------------------------------------------------------------------------
  logic       lfsr_fb;
  logic [7:0] lfsr_next;

  always_comb begin
    lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_next = {lfsr_q[6:0], lfsr_fb};
  end

  // ---------------------------------------------------------------------------------------------
  // Direction select. Only the highest-priority button is considered; if it is the reverse of
  // the current direction the request is dropped rather than falling through to a lower button.
  // ---------------------------------------------------------------------------------------------
  logic       btn_any;
  logic [1:0] btn_dir;
  logic [1:0] eff_dir;

  always_comb begin
    btn_any = BtnU | BtnD | BtnL | BtnR;
    if (BtnU) begin
      btn_dir = DirUp;
    end else if (BtnD) begin
      btn_dir = DirDown;
    end else if (BtnL) begin
      btn_dir = DirLeft;
    end else begin
      btn_dir = DirRight;
    end
    eff_dir = dir_q;
    if (btn_any && (btn_dir != (dir_q ^ 2'b01))) begin
      eff_dir = btn_dir;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Candidate head cell and wall detection.
  // ---------------------------------------------------------------------------------------------
  logic [3:0] head_row;
  logic [3:0] head_col;
  logic [7:0] next_head;
  logic       wall_hit;

  always_comb begin
    head_row  = seg_q[0][7:4];
    head_col  = seg_q[0][3:0];
    next_head = seg_q[0];
    wall_hit  = 1'b0;
    unique case (eff_dir)
      DirUp: begin
        wall_hit  = (head_row == 4'd0);
        next_head = {head_row - 4'd1, head_col};
      end
      DirDown: begin
        wall_hit  = (head_row == 4'd15);
        next_head = {head_row + 4'd1, head_col};
      end
      DirLeft: begin
        wall_hit  = (head_col == 4'd0);
        next_head = {head_row, head_col - 4'd1};
      end
      DirRight: begin
        wall_hit  = (head_col == 4'd15);
        next_head = {head_row, head_col + 4'd1};
      end
      default: begin
        wall_hit  = 1'b0;
        next_head = seg_q[0];
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Growth, self-collision and food-placement occupancy.
  // When not growing the tail vacates its cell on this move, so it is excluded from the check.
  // ---------------------------------------------------------------------------------------------
  logic       grow;
  logic [4:0] body_cmp_len;
  logic       self_hit;
  logic       food_blocked;
  logic       win_len;

  always_comb begin
    grow         = (next_head == food_q);
    body_cmp_len = grow ? {1'b0, len_q} : ({1'b0, len_q} - 5'd1);
    self_hit     = 1'b0;
    food_blocked = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if ((5'(k) < body_cmp_len) && (seg_q[k] == next_head)) begin
        self_hit = 1'b1;
      end
      if ((5'(k) < {1'b0, len_q}) && (seg_q[k] == lfsr_q)) begin
        food_blocked = 1'b1;
      end
    end
    win_len = (({1'b0, len_q} + 5'd1) == 5'(MAX_LEN));
  end

  // Start out of a terminal state re-initialises everything, exactly like Reset.
  logic restart;
  assign restart = Start && ((state_q == StWin) || (state_q == StLose));

  // ---------------------------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    len_d   = len_q;
    food_d  = food_q;
    pend_d  = pend_q;
    lfsr_d  = lfsr_next;
    for (int k = 0; k < 16; k++) begin
      seg_d[k] = seg_q[k];
    end

    unique case (state_q)
      StInit: begin
        if (Start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        dir_d = eff_dir;
        if (pend_q) begin
          // Ticks are dropped while a new food cell is being searched for.
          if (!food_blocked) begin
            food_d = lfsr_q;
            pend_d = 1'b0;
          end
        end else if (Tick) begin
          if (wall_hit || self_hit) begin
            state_d = StLose;
          end else begin
            for (int k = 1; k < 16; k++) begin
              seg_d[k] = seg_q[k-1];
            end
            seg_d[0] = next_head;
            if (grow) begin
              len_d = len_q + 4'd1;
              if (win_len) begin
                state_d = StWin;
              end else begin
                pend_d = 1'b1;
              end
            end
          end
        end
      end
      StWin, StLose: begin
        // Frozen; restart is handled by the register block.
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset || restart) begin
      state_q <= StInit;
      dir_q   <= DirRight;
      len_q   <= InitLen;
      food_q  <= InitFood;
      pend_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      seg_q[0] <= InitHead;
      seg_q[1] <= InitSeg1;
      seg_q[2] <= InitSeg2;
      for (int k = 3; k < 16; k++) begin
        seg_q[k] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      food_q  <= food_d;
      pend_q  <= pend_d;
      lfsr_q  <= lfsr_d;
      for (int k = 0; k < 16; k++) begin
        seg_q[k] <= seg_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    Locations_Flat = '0;
    for (int k = 0; k < 16; k++) begin
      Locations_Flat[127-8*k -: 8] = seg_q[k];
    end
  end

  assign Food   = food_q;
  assign Length = len_q;
  assign Qi     = state_q[0];
  assign Qc     = state_q[1];
  assign Qw     = state_q[2];
  assign Ql     = state_q[3];

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine. Two instances (MAX_LEN 15 and 4) share the same inputs
// and are each compared every cycle against a behavioural game model, plus directed checks.

`timescale 1ns/1ps

module tb_snake_engine;

  localparam logic [7:0] Seed = 8'hA5;
  localparam int SInit = 0;
  localparam int SRun  = 1;
  localparam int SWin  = 2;
  localparam int SLose = 3;

  logic clk = 1'b0;
  logic reset, start, btn_u, btn_d, btn_l, btn_r, tick;

  logic [7:0]   food_a, food_b;
  logic [3:0]   len_a, len_b;
  logic [127:0] flat_a, flat_b;
  logic         qi_a, qc_a, qw_a, ql_a;
  logic         qi_b, qc_b, qw_b, ql_b;

  snake_engine #(.MAX_LEN(15), .LFSR_SEED(Seed)) u_dut_a (
    .Clk(clk), .Reset(reset), .Start(start), .BtnU(btn_u), .BtnD(btn_d), .BtnL(btn_l),
    .BtnR(btn_r), .Tick(tick), .Food(food_a), .Length(len_a), .Locations_Flat(flat_a),
    .Qi(qi_a), .Qc(qc_a), .Qw(qw_a), .Ql(ql_a)
  );

  snake_engine #(.MAX_LEN(4), .LFSR_SEED(Seed)) u_dut_b (
    .Clk(clk), .Reset(reset), .Start(start), .BtnU(btn_u), .BtnD(btn_d), .BtnL(btn_l),
    .BtnR(btn_r), .Tick(tick), .Food(food_b), .Length(len_b), .Locations_Flat(flat_b),
    .Qi(qi_b), .Qc(qc_b), .Qw(qw_b), .Ql(ql_b)
  );

  always #5 clk = ~clk;

  // Game model: directions 0=up 1=down 2=left 3=right, state codes SInit..SLose.
  typedef struct packed {
    logic [1:0]       st;
    logic [3:0]       len;
    logic [1:0]       dir;
    logic             pend;
    logic [7:0]       food;
    logic [7:0]       lfsr;
    logic [15:0][7:0] seg;
  } mdl_t;

  mdl_t m15, m4;
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic int d_row(int d);
    int r;
    r = 0;
    if (d == 0) r = -1;
    if (d == 1) r = 1;
    return r;
  endfunction

  function automatic int d_col(int d);
    int c;
    c = 0;
    if (d == 2) c = -1;
    if (d == 3) c = 1;
    return c;
  endfunction

  function automatic bit opposite(int a, int b);
    return (d_row(a) == -d_row(b)) && (d_col(a) == -d_col(b));
  endfunction

  function automatic logic [3:0] btn_of(int d);
    logic [3:0] b;
    b = 4'b1000 >> d;
    return b;
  endfunction

  function automatic mdl_t init_m();
    mdl_t m;
    m        = '0;
    m.st     = 2'(SInit);
    m.len    = 4'd3;
    m.dir    = 2'd3;
    m.food   = 8'h8C;
    m.lfsr   = Seed;
    m.seg[0] = 8'h88;
    m.seg[1] = 8'h87;
    m.seg[2] = 8'h86;
    return m;
  endfunction

  function automatic mdl_t step_m(mdl_t m, bit rst, bit st, bit tk, logic [3:0] btn,
                                  int max_len);
    mdl_t       n;
    int         eff, b, r, c, limit;
    logic [7:0] nh;
    bit         grow, hit, occ;
    n      = m;
    n.lfsr = {m.lfsr[6:0], ^(m.lfsr & 8'hB8)};
    if (rst) return init_m();
    case (int'(m.st))
      SInit: if (st) n.st = 2'(SRun);
      SWin, SLose: if (st) return init_m();
      default: begin
        eff = int'(m.dir);
        if (btn != 4'b0000) begin
          if (btn[3]) b = 0;
          else if (btn[2]) b = 1;
          else if (btn[1]) b = 2;
          else b = 3;
          if (!opposite(b, eff)) eff = b;
        end
        n.dir = 2'(eff);
        if (m.pend) begin
          occ = 0;
          for (int k = 0; k < int'(m.len); k++) if (m.seg[k] == m.lfsr) occ = 1;
          if (!occ) begin
            n.food = m.lfsr;
            n.pend = 0;
          end
        end else if (tk) begin
          r = int'(m.seg[0][7:4]) + d_row(eff);
          c = int'(m.seg[0][3:0]) + d_col(eff);
          if (r < 0 || r > 15 || c < 0 || c > 15) begin
            n.st = 2'(SLose);
          end else begin
            nh    = {4'(r), 4'(c)};
            grow  = (nh == m.food);
            limit = grow ? int'(m.len) : int'(m.len) - 1;
            hit   = 0;
            for (int k = 0; k < limit; k++) if (m.seg[k] == nh) hit = 1;
            if (hit) begin
              n.st = 2'(SLose);
            end else begin
              for (int k = 15; k >= 1; k--) n.seg[k] = m.seg[k-1];
              n.seg[0] = nh;
              if (grow) begin
                n.len = m.len + 4'd1;
                if (int'(m.len) + 1 == max_len) n.st = 2'(SWin);
                else n.pend = 1;
              end
            end
          end
        end
      end
    endcase
    return n;
  endfunction

  task automatic check_dut(input string tag, input logic [3:0] q, input logic [3:0] len,
                           input logic [127:0] flat, input logic [7:0] food, input mdl_t m);
    logic [3:0]   exp_q;
    logic [127:0] exp_flat;
    exp_q = 4'b1000 >> m.st;
    for (int k = 0; k < 16; k++) exp_flat[127-8*k -: 8] = m.seg[k];
    n_assert++;
    assert (q === exp_q) else begin
      n_fail++;
      $error("FAIL %s_state: observed %b expected %b", tag, q, exp_q);
    end
    n_assert++;
    assert ($onehot(q)) else begin
      n_fail++;
      $error("FAIL %s_onehot: observed %b expected exactly one bit set", tag, q);
    end
    n_assert++;
    assert (len === m.len) else begin
      n_fail++;
      $error("FAIL %s_length: observed %0d expected %0d", tag, len, m.len);
    end
    n_assert++;
    assert (flat === exp_flat) else begin
      n_fail++;
      $error("FAIL %s_locations: observed %h expected %h", tag, flat, exp_flat);
    end
    n_assert++;
    assert (food === m.food) else begin
      n_fail++;
      $error("FAIL %s_food: observed %h expected %h", tag, food, m.food);
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit st, input bit tk, input logic [3:0] btn);
    reset = rst;
    start = st;
    tick  = tk;
    {btn_u, btn_d, btn_l, btn_r} = btn;
    @(posedge clk);
    m15 = step_m(m15, rst, st, tk, btn, 15);
    m4  = step_m(m4, rst, st, tk, btn, 4);
    #1;
    check_dut("max15", {qi_a, qc_a, qw_a, ql_a}, len_a, flat_a, food_a, m15);
    check_dut("max4", {qi_b, qc_b, qw_b, ql_b}, len_b, flat_b, food_b, m4);
  endtask

  // Move with the given buttons, then idle a random few cycles with buttons released.
  task automatic tk_move(input logic [3:0] btn);
    cyc(0, 0, 1, btn);
    repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 4'b0000);
  endtask

  task automatic wait_place();
    for (int i = 0; i < 300 && m15.pend; i++) cyc(0, 0, 0, 4'b0000);
  endtask

  // Three-turn U: perpendicular, back against the old direction, then back across.
  task automatic uturn();
    int d, p;
    d = int'(m15.dir);
    if (d >= 2) p = (m15.seg[0][7:4] > 4'd0) ? 0 : 1;
    else p = (m15.seg[0][3:0] > 4'd0) ? 2 : 3;
    cyc(0, 0, 1, btn_of(p));
    cyc(0, 0, 1, btn_of(d ^ 1));
    cyc(0, 0, 1, btn_of(p ^ 1));
  endtask

  function automatic logic [3:0] choose_btn(mdl_t m);
    int hr, hc, fr, fc, d, h, v, pick;
    hr = int'(m.seg[0][7:4]);
    hc = int'(m.seg[0][3:0]);
    fr = int'(m.food[7:4]);
    fc = int'(m.food[3:0]);
    d  = int'(m.dir);
    h  = -1;
    v  = -1;
    if (fc > hc) h = 3;
    else if (fc < hc) h = 2;
    if (fr < hr) v = 0;
    else if (fr > hr) v = 1;
    if (h >= 0 && !opposite(h, d)) pick = h;
    else if (v >= 0 && !opposite(v, d)) pick = v;
    else if (d >= 2) pick = (hr > 0) ? 0 : 1;
    else pick = (hc > 0) ? 2 : 3;
    return btn_of(pick);
  endfunction

  initial begin
    bit         r_rst, r_st, r_tk;
    logic [3:0] r_btn;
    bit         free;
    reset = 1'b1;
    start = 1'b0;
    tick  = 1'b0;
    {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
    m15 = init_m();
    m4  = init_m();

    // Reset values
    cyc(1, 0, 0, 4'b0000);
    cyc(1, 0, 0, 4'b0000);
    chk("reset_q", {qi_a, qc_a, qw_a, ql_a}, 4'b1000);
    chk("reset_len", len_a, 4'd3);
    chk("reset_flat", flat_a, {24'h888786, 104'h0});
    chk("reset_food", food_a, 8'h8C);

    // Start and three plain moves
    cyc(0, 1, 0, 4'b0000);
    chk("start_qc", qc_a, 1'b1);
    repeat (3) tk_move(4'b0000);
    chk("three_ticks_head", flat_a[127:104], 24'h8B8A89);
    chk("three_ticks_len", len_a, 4'd3);
    chk("three_ticks_qc", qc_a, 1'b1);

    // Eat the food at 8C: MAX_LEN 15 grows, MAX_LEN 4 wins on the same edge
    cyc(0, 0, 1, 4'b0000);
    chk("grow_len", len_a, 4'd4);
    chk("grow_seg3", flat_a[103:96], 8'h89);
    chk("win_qw", qw_b, 1'b1);
    chk("win_len", len_b, 4'd4);
    for (int i = 0; i < 256 && food_a == 8'h8C; i++) cyc(0, 0, 0, 4'b0000);
    free = (food_a != 8'h8C);
    for (int k = 0; k < 4; k++) if (flat_a[127-8*k -: 8] == food_a) free = 0;
    chk("food_replaced_free", free, 1'b1);
    chk("win_no_placement", food_b, 8'h8C);
    wait_place();

    // Length 4: the U-turn ends in the vacating tail cell
    uturn();
    repeat (2) cyc(0, 0, 0, 4'b0000);

    // Steer to the next food to reach length 5, then U-turn into the body
    for (int g = 0; g < 600 && m15.st == 2'(SRun) && !(m15.len == 4'd5 && !m15.pend); g++) begin
      if (m15.pend) cyc(0, 0, 0, 4'b0000);
      else cyc(0, 0, 1, choose_btn(m15));
    end
    uturn();
    repeat (3) cyc(0, 0, 1, 4'b0000);

    // Random play
    for (int i = 0; i < 500; i++) begin
      r_rst = ($urandom_range(0, 149) == 0);
      r_st  = ($urandom_range(0, 29) == 0);
      r_tk  = ($urandom_range(0, 2) == 0);
      r_btn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cyc(r_rst, r_st, r_tk, r_btn);
    end

    // Reversal ignored, priority U over R, then up into the top wall
    cyc(1, 0, 0, 4'b0000);
    cyc(0, 1, 0, 4'b0000);
    tk_move(4'b0010);
    chk("reverse_ignored_head", flat_a[127:120], 8'h89);
    tk_move(4'b1001);
    chk("priority_u_head", flat_a[127:120], 8'h79);
    repeat (7) tk_move(4'b1000);
    chk("top_row_head", flat_a[127:120], 8'h09);
    chk("top_row_qc", qc_a, 1'b1);
    cyc(0, 0, 1, 4'b1000);
    chk("wall_ql", ql_a, 1'b1);
    chk("wall_flat_kept", flat_a[127:32], 96'h091929394959697989888786);
    repeat (2) cyc(0, 0, 1, 4'b0010);
    chk("lose_frozen_head", flat_a[127:120], 8'h09);
    chk("lose_frozen_ql", ql_a, 1'b1);
    cyc(0, 1, 0, 4'b0000);
    chk("restart_qi", {qi_a, qc_a, qw_a, ql_a}, 4'b1000);
    chk("restart_flat", flat_a, {24'h888786, 104'h0});
    chk("restart_food", food_a, 8'h8C);

    // Reset while food placement is pending
    cyc(0, 1, 0, 4'b0000);
    repeat (4) cyc(0, 0, 1, 4'b0000);
    cyc(1, 0, 0, 4'b0000);
    chk("midplace_reset_q", {qi_a, qc_a, qw_a, ql_a}, 4'b1000);
    chk("midplace_reset_len", len_a, 4'd3);
    chk("midplace_reset_flat", flat_a, {24'h888786, 104'h0});
    chk("midplace_reset_food", food_a, 8'h8C);
    // The next placement exposes the reloaded LFSR sequence
    cyc(0, 1, 0, 4'b0000);
    repeat (4) tk_move(4'b0000);
    wait_place();
    repeat (4) cyc(0, 0, 0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
